pattern_sweep_ctrl: RTL and testbench
=====================================

// Module: pattern_sweep_ctrl
// PURPOSE
//  Sequences a combinational learned circuit (pi*/po* ports) through a contiguous range of input patterns.
//  Per pattern: drives the vector, waits a settle window, captures the outputs, hands {pattern, outputs} to a
//  result sink over a valid/ready handshake. Replaces free-running increment-and-dump benches; sink may stall.
// PARAMETERS
//  NUM_PI         8   DUT primary-input width (1..20)
//  NUM_PO         4   DUT primary-output width (1..16)
//  SETTLE_CYCLES  1   cycles each pattern is held before capture (>=1)
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  start        in   1          pulse; begins a sweep when idle
//  abort        in   1          sync; cancels sweep in progress
//  pat_first    in   NUM_PI     first pattern, sampled on accepted start
//  pat_last     in   NUM_PI     last pattern, sampled on accepted start
//  dut_pi       out  NUM_PI     vector to DUT inputs
//  dut_po       in   NUM_PO     DUT outputs
//  res_valid    out  1          result available
//  res_ready    in   1          sink accepts result
//  res_pattern  out  NUM_PI     pattern that produced res_po
//  res_po       out  NUM_PO     captured DUT outputs
//  res_count    out  NUM_PI+1   results accepted in current/last sweep
//  busy         out  1          high in any state except IDLE
//  done         out  1          one-cycle pulse at normal sweep completion
// BEHAVIOUR
//  Reset: state IDLE; dut_pi, res_pattern, res_po, res_count = 0; res_valid, busy, done = 0.
//  FSM states IDLE, SETTLE, EMIT, DONE:
//  - IDLE: start=1 -> latch pat_first/pat_last, pattern<=pat_first, res_count<=0, settle_ctr<=SETTLE_CYCLES-1, ->SETTLE.
//  - SETTLE: dut_pi=pattern. settle_ctr==0 -> res_po<=dut_po, res_pattern<=pattern, ->EMIT; else decrement.
//    SETTLE lasts exactly SETTLE_CYCLES cycles.
//  - EMIT: res_valid=1; res_pattern/res_po stable until handshake. On res_valid&&res_ready: res_count+1;
//    pattern==pat_last -> DONE; else pattern<=pattern+1 (mod 2^NUM_PI), reload settle_ctr, ->SETTLE.
//  - DONE: done=1 for this one cycle, busy=1; ->IDLE.
//  Latency: start sampled at edge k -> dut_pi=pat_first from k+1 -> res_valid from k+1+SETTLE_CYCLES.
//    res_ready tied high -> one result per SETTLE_CYCLES+1 cycles.
//  Range rules:
//  - pat_first==pat_last: exactly one result.
//  - pat_last<pat_first: sweep wraps through all-ones to 0.
//  - full sweep 0..2^NUM_PI-1: res_count ends at 2^NUM_PI (hence width NUM_PI+1).
//  Boundaries:
//  - start while busy: ignored.
//  - abort in SETTLE/EMIT/DONE: ->IDLE next cycle; res_valid drops; no done pulse; res_count keeps accepted total.
//  - abort beats a same-cycle handshake: that result is not counted.
//  - abort and start in same cycle while IDLE: start wins.
//  - res_ready while res_valid=0: ignored.
//  - dut_pi holds last driven pattern in IDLE.
//  - rst_n low mid-sweep: all outputs to reset values immediately.
// CONFIGURATION
//  SWEEP_MISR_EN defined:
//  - adds output port signature [15:0]: reset 16'hFFFF, reloaded to 16'hFFFF on accepted start.
//  - each accepted handshake: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {zero-pad, res_po}.
//  - value is final from the DONE cycle onward.
//  SWEEP_MISR_EN undefined: no signature port, no MISR logic; all other behaviour identical.
// TESTING
//  1 NUM_PI=8, SETTLE=1, ready=1, first=0x00, last=0xFF, DUT po=pi[3:0]
//    -> 256 results, res_po==res_pattern[3:0], first res_valid 2 cycles after start, done once, res_count=256.
//  2 first=0xFE, last=0x01
//    -> res_pattern sequence FE,FF,00,01; res_count=4.
//  3 first=last=0x5A, SETTLE=3
//    -> one result, res_valid 4 cycles after start, then done.
//  4 ready low 5 cycles per result
//    -> res_valid/res_pattern/res_po stable while stalled; no pattern skipped or duplicated.
//  5 abort in EMIT of 3rd result, same cycle as ready
//    -> IDLE next cycle, no done, res_count=2; a new start sweeps correctly.
//  6 SWEEP_MISR_EN, sweep 0..3, po=0
//    -> signature matches reference MISR model; start during busy leaves sweep unchanged.

Source files
------------

// File: rtl/pattern_sweep_ctrl.sv
// Steps a combinational circuit through a contiguous input-pattern range and hands each captured result to a sink.
// Optional output signature (16-bit MISR over accepted results) is enabled by defining SWEEP_MISR_EN.
module pattern_sweep_ctrl #(
    parameter int NUM_PI        = 8,
    parameter int NUM_PO        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_PI-1:0] pat_first,
    input  logic [NUM_PI-1:0] pat_last,
    output logic [NUM_PI-1:0] dut_pi,
    input  logic [NUM_PO-1:0] dut_po,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [NUM_PI-1:0] res_pattern,
    output logic [NUM_PO-1:0] res_po,
    output logic [NUM_PI:0]   res_count,
    output logic              busy,
`ifdef SWEEP_MISR_EN
    output logic              done,
    output logic [15:0]       signature
`else
    output logic              done
`endif
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_INIT = SCW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t            state;
    logic [NUM_PI-1:0] pattern;
    logic [NUM_PI-1:0] last_q;
    logic [SCW-1:0]    settle_ctr;

    // The current pattern register is the DUT drive, so dut_pi naturally holds its last value in IDLE.
    assign dut_pi = pattern;

`ifdef SWEEP_MISR_EN
    logic [15:0] sig_next;

    always_comb begin
        sig_next = {signature[14:0], 1'b0}
                 ^ (signature[15] ? 16'h1021 : 16'h0000)
                 ^ 16'(res_po);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pattern     <= '0;
            last_q      <= '0;
            settle_ctr  <= '0;
            res_valid   <= 1'b0;
            res_pattern <= '0;
            res_po      <= '0;
            res_count   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SWEEP_MISR_EN
            signature   <= 16'hFFFF;
`endif
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                // Abort outranks a same-cycle handshake: nothing is counted or folded in.
                state     <= ST_IDLE;
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pattern    <= pat_first;
                            last_q     <= pat_last;
                            res_count  <= '0;
                            settle_ctr <= SETTLE_INIT;
                            busy       <= 1'b1;
                            state      <= ST_SETTLE;
`ifdef SWEEP_MISR_EN
                            signature  <= 16'hFFFF;
`endif
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_ctr == '0) begin
                            res_po      <= dut_po;
                            res_pattern <= pattern;
                            res_valid   <= 1'b1;
                            state       <= ST_EMIT;
                        end else begin
                            settle_ctr <= settle_ctr - 1'b1;
                        end
                    end
                    ST_EMIT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            res_count <= res_count + 1'b1;
`ifdef SWEEP_MISR_EN
                            signature <= sig_next;
`endif
                            if (pattern == last_q) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                pattern    <= pattern + 1'b1;
                                settle_ctr <= SETTLE_INIT;
                                state      <= ST_SETTLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Directed bench for pattern_sweep_ctrl: two instances (settle 1 and 3) driving a po = pi[3:0] model circuit.
// Define SWEEP_MISR_EN to also cover the signature output.
module tb_pattern_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, res_ready, sel, po_zero;
    logic [7:0] pat_first, pat_last;

    logic [7:0] m_pi, m_pat, s_pi, s_pat;
    logic [3:0] m_po_in, m_po, s_po_in, s_po;
    logic [8:0] m_cnt, s_cnt;
    logic       m_valid, m_busy, m_done, s_valid, s_busy, s_done;
    logic       m_start, s_start;
`ifdef SWEEP_MISR_EN
    logic [15:0] m_sig, s_sig, v_sig;
`endif

    logic [7:0] v_pi, v_pat;
    logic [3:0] v_po;
    logic [8:0] v_cnt;
    logic       v_valid, v_busy, v_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign m_start = start && !sel;
    assign s_start = start &&  sel;
    assign m_po_in = po_zero ? 4'h0 : m_pi[3:0];
    assign s_po_in = po_zero ? 4'h0 : s_pi[3:0];

    assign v_pi    = sel ? s_pi    : m_pi;
    assign v_pat   = sel ? s_pat   : m_pat;
    assign v_po    = sel ? s_po    : m_po;
    assign v_cnt   = sel ? s_cnt   : m_cnt;
    assign v_valid = sel ? s_valid : m_valid;
    assign v_busy  = sel ? s_busy  : m_busy;
    assign v_done  = sel ? s_done  : m_done;
`ifdef SWEEP_MISR_EN
    assign v_sig   = sel ? s_sig   : m_sig;
`endif

    pattern_sweep_ctrl #(.NUM_PI(8), .NUM_PO(4), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(m_start), .abort(abort),
        .pat_first(pat_first), .pat_last(pat_last), .dut_pi(m_pi), .dut_po(m_po_in),
        .res_valid(m_valid), .res_ready(res_ready), .res_pattern(m_pat), .res_po(m_po),
        .res_count(m_cnt), .busy(m_busy),
`ifdef SWEEP_MISR_EN
        .done(m_done), .signature(m_sig)
`else
        .done(m_done)
`endif
    );

    pattern_sweep_ctrl #(.NUM_PI(8), .NUM_PO(4), .SETTLE_CYCLES(3)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(abort),
        .pat_first(pat_first), .pat_last(pat_last), .dut_pi(s_pi), .dut_po(s_po_in),
        .res_valid(s_valid), .res_ready(res_ready), .res_pattern(s_pat), .res_po(s_po),
        .res_count(s_cnt), .busy(s_busy),
`ifdef SWEEP_MISR_EN
        .done(s_done), .signature(s_sig)
`else
        .done(s_done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

`ifdef SWEEP_MISR_EN
    function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] po);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, po};
    endfunction
`endif

    // Runs one sweep on the selected instance; stall = ready-low cycles per result, poke = start pulse mid-sweep.
    task automatic sweep(input logic [7:0] first, input logic [7:0] last, input int stall,
                         input int exp_n, input bit poke);
        logic [7:0] exp_pat, hold_pat;
        logic [3:0] hold_po, exp_po;
        int got, wait_cnt, first_v;
        bit fin;
`ifdef SWEEP_MISR_EN
        logic [15:0] exp_sig;
        exp_sig = 16'hFFFF;
`endif
        @(negedge clk);
        pat_first = first;
        pat_last  = last;
        start     = 1'b1;
        res_ready = (stall == 0);
        @(negedge clk);
        start    = 1'b0;
        exp_pat  = first;
        got      = 0;
        wait_cnt = 0;
        first_v  = -1;
        fin      = 1'b0;
        hold_pat = '0;
        hold_po  = '0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            start = poke && (cyc == 2);
            if (poke && cyc == 2) pat_first = 8'hAA;
            res_ready = (stall == 0) || (wait_cnt >= stall);
            if (v_done) begin
                fin = 1'b1;
                check("done_res_count", 32'(v_cnt), 32'(exp_n));
                check("done_results", 32'(got), 32'(exp_n));
                check("done_busy", 32'(v_busy), 32'd1);
                check("done_valid", 32'(v_valid), 32'd0);
`ifdef SWEEP_MISR_EN
                check("done_signature", 32'(v_sig), 32'(exp_sig));
`endif
            end else if (v_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    check("first_valid_latency", 32'(cyc), sel ? 32'd3 : 32'd1);
                end
                exp_po = po_zero ? 4'h0 : exp_pat[3:0];
                if (wait_cnt == 0) begin
                    check("res_pattern", 32'(v_pat), 32'(exp_pat));
                    check("res_po", 32'(v_po), 32'(exp_po));
                    hold_pat = v_pat;
                    hold_po  = v_po;
                end else begin
                    check("stall_pattern", 32'(v_pat), 32'(hold_pat));
                    check("stall_po", 32'(v_po), 32'(hold_po));
                end
                if (res_ready) begin
                    got++;
`ifdef SWEEP_MISR_EN
                    exp_sig = misr(exp_sig, exp_po);
`endif
                    exp_pat  = exp_pat + 8'd1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!fin) check("sweep_timeout", 32'd0, 32'd1);
        check("post_done_pulse", 32'(v_done), 32'd0);
        check("post_done_busy", 32'(v_busy), 32'd0);
        check("pi_hold_idle", 32'(v_pi), 32'(last));
    endtask

    initial begin
        bit hit;
        int got;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        sel       = 1'b0;
        po_zero   = 1'b0;
        pat_first = '0;
        pat_last  = '0;

        #12;
        check("rst_pi", 32'(m_pi), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(m_cnt), 32'd0);
        check("rst_busy_done", 32'({m_busy, m_done}), 32'd0);
`ifdef SWEEP_MISR_EN
        check("rst_signature", 32'(m_sig), 32'h0000_FFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // full 8-bit range, ready high
        sweep(8'h00, 8'hFF, 0, 256, 1'b0);
        // wrapping range, with a start pulse while busy
        sweep(8'hFE, 8'h01, 0, 4, 1'b1);
        // single pattern on the 3-cycle-settle instance
        sel = 1'b1;
        sweep(8'h5A, 8'h5A, 0, 1, 1'b0);
        sel = 1'b0;
        // sink stalls 5 cycles per result
        sweep(8'h20, 8'h23, 5, 4, 1'b0);

        // abort during EMIT of the 3rd result together with ready
        @(negedge clk);
        pat_first = 8'h10;
        pat_last  = 8'h20;
        res_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        got   = 0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            if (m_done) check("abort_sweep_no_done", 32'd1, 32'd0);
            if (m_valid && got == 2) begin
                abort = 1'b1;
                hit   = 1'b1;
            end else begin
                if (m_valid) got++;
                @(negedge clk);
            end
        end
        if (!hit) check("abort_timeout", 32'd0, 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_done", 32'(m_done), 32'd0);
        check("abort_count", 32'(m_cnt), 32'd2);
        check("abort_pi_hold", 32'(m_pi), 32'h12);
        @(negedge clk);
        check("abort_no_late_done", 32'(m_done), 32'd0);
        sweep(8'h30, 8'h32, 0, 3, 1'b0);

        // start and abort together in IDLE: start wins; then abort from SETTLE
        @(negedge clk);
        pat_first = 8'h40;
        pat_last  = 8'h45;
        start     = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort_busy", 32'(m_busy), 32'd1);
        check("start_beats_abort_pi", 32'(m_pi), 32'h40);
        check("start_clears_count", 32'(m_cnt), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_settle_busy", 32'(m_busy), 32'd0);
        check("abort_settle_valid", 32'(m_valid), 32'd0);

`ifdef SWEEP_MISR_EN
        po_zero = 1'b1;
        sweep(8'h00, 8'h03, 0, 4, 1'b1);
        check("misr_hand_value", 32'(m_sig), 32'h0000_0E1F);
        po_zero = 1'b0;
`endif

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        pat_first = 8'h80;
        pat_last  = 8'hFF;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pi", 32'(m_pi), 32'd0);
        check("midrst_pat_po", 32'({m_pat, m_po}), 32'd0);
        check("midrst_count", 32'(m_cnt), 32'd0);
        check("midrst_flags", 32'({m_valid, m_busy, m_done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
